nim_match_ctrl: RTL

Parametrised match controller for the pile-taking game: it holds PILES piles of PW-bit counts, a selection cursor and take amount driven by single-cycle key pulses, alternates players, and validates moves. It detects the end of each round, keeps per-player round scores and ends the match when a player reaches the target score. It sits between the PS2 key decoder and the display/page logic and replaces the fixed 10×4-bit, unvalidated game loop.

---
 rtl/nim_match_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/nim_match_ctrl.sv
// nim_match_ctrl: match controller for the pile-taking game.
// Holds the pile counts, the cursor/amount selection and the current player.
// It validates each commit, scores rounds, and ends the match at the target score.
module nim_match_ctrl #(
  parameter int PILES = 10,
  parameter int PW    = 4,
  parameter int SW    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [SW-1:0]              target,
  input  logic [PILES*PW-1:0]        init_piles,
  input  logic                       cur_left,
  input  logic                       cur_right,
  input  logic                       amt_up,
  input  logic                       amt_down,
  input  logic                       commit,
  output logic [PILES*PW-1:0]        piles,
  output logic [$clog2(PILES)-1:0]   cursor,
  output logic [PW-1:0]              amount,
  output logic                       player,
  output logic [SW-1:0]              score0,
  output logic [SW-1:0]              score1,
  output logic [1:0]                 state,
  output logic                       winner,
  output logic                       move_err
);

  localparam int CW = $clog2(PILES);
  localparam logic [CW-1:0] CUR_LAST = CW'(PILES - 1);
  localparam logic [PW-1:0] AMT_MAX  = '1;
  localparam logic [PW-1:0] AMT_ONE  = PW'(1);
  localparam logic [SW-1:0] SCORE_ONE = SW'(1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'b00,
    S_PLAY       = 2'b01,
    S_ROUND_END  = 2'b10,
    S_MATCH_OVER = 2'b11
  } state_t;

  state_t                state_reg, state_next;
  logic [PILES*PW-1:0]   piles_reg, piles_next;
  logic [PILES*PW-1:0]   init_reg, init_next;
  logic [SW-1:0]         target_reg, target_next;
  logic [CW-1:0]         cursor_reg, cursor_next;
  logic [PW-1:0]         amount_reg, amount_next;
  logic                  player_reg, player_next;
  logic [SW-1:0]         score0_reg, score0_next;
  logic [SW-1:0]         score1_reg, score1_next;
  logic                  winner_reg, winner_next;
  logic                  move_err_reg, move_err_next;

  // Count of the pile under the cursor, and the round winner's score after increment.
  logic [PW-1:0] sel_pile;
  logic [SW-1:0] win_score;
  assign sel_pile  = piles_reg[cursor_reg*PW +: PW];
  assign win_score = (player_reg ? score1_reg : score0_reg) + SCORE_ONE;

  // State register: every output is taken straight from these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      piles_reg    <= '0;
      init_reg     <= '0;
      target_reg   <= '0;
      cursor_reg   <= '0;
      amount_reg   <= AMT_ONE;
      player_reg   <= 1'b0;
      score0_reg   <= '0;
      score1_reg   <= '0;
      winner_reg   <= 1'b0;
      move_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      piles_reg    <= piles_next;
      init_reg     <= init_next;
      target_reg   <= target_next;
      cursor_reg   <= cursor_next;
      amount_reg   <= amount_next;
      player_reg   <= player_next;
      score0_reg   <= score0_next;
      score1_reg   <= score1_next;
      winner_reg   <= winner_next;
      move_err_reg <= move_err_next;
    end
  end

  // Next-state logic. Priority is abort, then commit, then cursor/amount keys.
  always_comb begin
    state_next    = state_reg;
    piles_next    = piles_reg;
    init_next     = init_reg;
    target_next   = target_reg;
    cursor_next   = cursor_reg;
    amount_next   = amount_reg;
    player_next   = player_reg;
    score0_next   = score0_reg;
    score1_next   = score1_reg;
    winner_next   = winner_reg;
    move_err_next = 1'b0;

    if (abort) begin
      // The latched init copy and target are left stale on purpose.
      state_next  = S_IDLE;
      piles_next  = '0;
      score0_next = '0;
      score1_next = '0;
      player_next = 1'b0;
      cursor_next = '0;
      amount_next = AMT_ONE;
    end else begin
      case (state_reg)
        S_IDLE, S_MATCH_OVER: begin
          // An all-empty board would end the round with no legal move, so refuse it.
          if (start && (init_piles != '0)) begin
            init_next   = init_piles;
            target_next = (target == '0) ? SCORE_ONE : target;
            piles_next  = init_piles;
            score0_next = '0;
            score1_next = '0;
            player_next = 1'b0;
            cursor_next = '0;
            amount_next = AMT_ONE;
            state_next  = S_PLAY;
          end
        end
        S_PLAY: begin
          if (commit) begin
            if ((amount_reg != '0) && (amount_reg <= sel_pile)) begin
              piles_next[cursor_reg*PW +: PW] = sel_pile - amount_reg;
              amount_next = AMT_ONE;
              // Taking the last stone wins the round for the mover.
              if (piles_next == '0) state_next = S_ROUND_END;
              else                  player_next = ~player_reg;
            end else begin
              move_err_next = 1'b1;
            end
          end else begin
            if (cur_right && !cur_left)
              cursor_next = (cursor_reg == CUR_LAST) ? '0 : cursor_reg + CW'(1);
            else if (cur_left && !cur_right)
              cursor_next = (cursor_reg == '0) ? CUR_LAST : cursor_reg - CW'(1);
            if (amt_up && !amt_down)
              amount_next = (amount_reg == AMT_MAX) ? AMT_MAX : amount_reg + AMT_ONE;
            else if (amt_down && !amt_up)
              amount_next = (amount_reg <= AMT_ONE) ? AMT_ONE : amount_reg - AMT_ONE;
          end
        end
        S_ROUND_END: begin
          if (player_reg) score1_next = win_score;
          else            score0_next = win_score;
          if (win_score >= target_reg) begin
            winner_next = player_reg;
            state_next  = S_MATCH_OVER;
          end else begin
            // The round loser opens the next round on a fresh board.
            piles_next  = init_reg;
            player_next = ~player_reg;
            cursor_next = '0;
            amount_next = AMT_ONE;
            state_next  = S_PLAY;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign piles    = piles_reg;
  assign cursor   = cursor_reg;
  assign amount   = amount_reg;
  assign player   = player_reg;
  assign score0   = score0_reg;
  assign score1   = score1_reg;
  assign state    = state_reg;
  assign winner   = winner_reg;
  assign move_err = move_err_reg;

endmodule
